// File: rtl/stage2_cnn_core_param.sv
// ============================================================================
//  Module   : stage2_cnn_core_param
//  Purpose  : Streaming KxK convolution with stride 1/2, requantisation, ReLU
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage2_cnn_core_param #(
    parameter int CI    = 3,
    parameter int CO    = 3,
    parameter int K     = 5,
    parameter int IX    = 12,
    parameter int IY    = 12,
    parameter int IBW   = 20,
    parameter int W_BW  = 8,
    parameter int B_BW  = 16,
    parameter int OBW   = 32,
    parameter int SHIFT = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CO*CI*K*K*W_BW-1:0]   i_cnn_weight,
    input  logic [CO*B_BW-1:0]          i_cnn_bias,
    input  logic                        i_stride2,
    input  logic                        i_relu_en,
    input  logic                        i_in_valid,
    input  logic [CI*IBW-1:0]           i_in_fmap,
    output logic                        o_ot_valid,
    output logic [CO*OBW-1:0]           o_ot_fmap,
    output logic                        o_frame_done
);

    localparam int c_ACC_BW = IBW + W_BW + $clog2(CI*K*K) + 1;
    localparam int c_PW     = IBW + W_BW;
    localparam int c_EW     = ((c_ACC_BW > OBW) ? c_ACC_BW : OBW) + 1;
    localparam int c_CW     = $clog2(IX);
    localparam int c_RW     = $clog2(IY);
    localparam int c_PIX    = CI * IBW;

    localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(IX - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(IY - 1);
    localparam logic [c_CW-1:0] c_COL_K     = c_CW'(K - 1);
    localparam logic [c_RW-1:0] c_ROW_K     = c_RW'(K - 1);
    localparam logic [c_CW-1:0] c_COL_LAST2 = c_CW'(K - 1 + 2*((IX - K)/2));
    localparam logic [c_RW-1:0] c_ROW_LAST2 = c_RW'(K - 1 + 2*((IY - K)/2));
    localparam logic            c_KM1_ODD   = ((K - 1) % 2) == 1;

    localparam logic signed [c_EW-1:0] c_OMAX = {{(c_EW-OBW+1){1'b0}}, {(OBW-1){1'b1}}};
    localparam logic signed [c_EW-1:0] c_OMIN = {{(c_EW-OBW+1){1'b1}}, {(OBW-1){1'b0}}};

    logic [c_CW-1:0]  r_col;
    logic [c_RW-1:0]  r_row;
    logic             r_s2;
    logic             r_relu;
    logic             r_v1, r_v2, r_v3;
    logic             r_d1, r_d2, r_d3;
    logic             r_rl1, r_rl2, r_rl3;

    logic [c_PIX-1:0]           r_lb  [K-1][IX];
    logic [c_PIX-1:0]           r_win [K][K];
    logic signed [c_PW-1:0]     r_prod [CO][CI][K][K];
    logic signed [c_ACC_BW-1:0] r_acc [CO];

    logic signed [c_ACC_BW-1:0] w_sum [CO];
    logic signed [c_ACC_BW-1:0] w_sh  [CO];
    logic signed [c_EW-1:0]     w_ext [CO];
    logic [CO*OBW-1:0]          w_q;
    logic                       w_accept;
    logic                       w_fire;
    logic                       w_last;

    assign w_accept = i_in_valid & ~reset;

    // Stride-2 phase is taken relative to the first legal window position K-1.
    assign w_fire = w_accept && (r_row >= c_ROW_K) && (r_col >= c_COL_K) &&
                    (!r_s2 || (!(r_row[0] ^ c_KM1_ODD) && !(r_col[0] ^ c_KM1_ODD)));

    assign w_last = r_s2 ? ((r_row == c_ROW_LAST2) && (r_col == c_COL_LAST2))
                         : ((r_row == c_ROW_LAST)  && (r_col == c_COL_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_s2         <= 1'b0;
            r_relu       <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_v3         <= 1'b0;
            r_d1         <= 1'b0;
            r_d2         <= 1'b0;
            r_d3         <= 1'b0;
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_ot_fmap    <= '0;
        end else begin
            r_v1         <= w_fire;
            r_d1         <= w_fire && w_last;
            r_v2         <= r_v1;
            r_d2         <= r_d1;
            r_v3         <= r_v2;
            r_d3         <= r_d2;
            o_ot_valid   <= r_v3;
            o_frame_done <= r_d3;
            if (r_v3) begin
                o_ot_fmap <= w_q;
            end
            if (w_accept) begin
                if ((r_row == '0) && (r_col == '0)) begin
                    r_s2   <= i_stride2;
                    r_relu <= i_relu_en;
                end
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Line buffer shifts vertically per column; window shifts left and takes
    // the freshly assembled column (buffered rows plus the incoming pixel).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K-1; kx++) begin
                    r_win[ky][kx] <= r_win[ky][kx+1];
                end
            end
            for (int ky = 0; ky < K-1; ky++) begin
                r_win[ky][K-1] <= r_lb[ky][r_col];
            end
            r_win[K-1][K-1] <= i_in_fmap;
            for (int ky = 0; ky < K-2; ky++) begin
                r_lb[ky][r_col] <= r_lb[ky+1][r_col];
            end
            r_lb[K-2][r_col] <= i_in_fmap;
        end
    end

    always_ff @(posedge clk) begin
        r_rl1 <= r_relu;
        r_rl2 <= r_rl1;
        r_rl3 <= r_rl2;
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++) begin
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        r_prod[co][ci][ky][kx] <=
                            $signed({{W_BW{r_win[ky][kx][ci*IBW+IBW-1]}},
                                     r_win[ky][kx][ci*IBW +: IBW]}) *
                            $signed({{IBW{i_cnn_weight[((((co*CI+ci)*K+ky)*K+kx)*W_BW)+W_BW-1]}},
                                     i_cnn_weight[((((co*CI+ci)*K+ky)*K+kx)*W_BW) +: W_BW]});
                    end
                end
            end
            r_acc[co] <= w_sum[co];
        end
    end

    always_comb begin
        w_sum = '{default: '0};
        for (int co = 0; co < CO; co++) begin
            w_sum[co] = {{(c_ACC_BW-B_BW){i_cnn_bias[co*B_BW+B_BW-1]}},
                         i_cnn_bias[co*B_BW +: B_BW]};
            for (int ci = 0; ci < CI; ci++) begin
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        w_sum[co] = w_sum[co] +
                            {{(c_ACC_BW-c_PW){r_prod[co][ci][ky][kx][c_PW-1]}},
                             r_prod[co][ci][ky][kx]};
                    end
                end
            end
        end
    end

    // Saturation happens before ReLU, so a clamped negative still maps to 0.
    always_comb begin
        w_q   = '0;
        w_sh  = '{default: '0};
        w_ext = '{default: '0};
        for (int co = 0; co < CO; co++) begin
            w_sh[co]  = r_acc[co] >>> SHIFT;
            w_ext[co] = {{(c_EW-c_ACC_BW){w_sh[co][c_ACC_BW-1]}}, w_sh[co]};
            if (w_ext[co] > c_OMAX) begin
                w_q[co*OBW +: OBW] = c_OMAX[OBW-1:0];
            end else if (w_ext[co] < c_OMIN) begin
                w_q[co*OBW +: OBW] = c_OMIN[OBW-1:0];
            end else begin
                w_q[co*OBW +: OBW] = w_ext[co][OBW-1:0];
            end
            if (r_rl3 && w_ext[co][c_EW-1]) begin
                w_q[co*OBW +: OBW] = '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stage2_cnn_core_param.sv
// ============================================================================
//  Module   : tb_stage2_cnn_core_param
//  Purpose  : Scoreboard bench for two instances (OBW 32/SHIFT 0, OBW 16/SHIFT 2)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage2_cnn_core_param;

    localparam int CI = 3, CO = 3, K = 5, IX = 12, IY = 12;
    localparam int IBW = 20, W_BW = 8, B_BW = 16;

    logic clk = 1'b0;
    logic reset;
    logic [CO*CI*K*K*W_BW-1:0] wvec;
    logic [CO*B_BW-1:0]        bvec;
    logic                      stride2, relu, in_valid;
    logic [CI*IBW-1:0]         in_fmap;
    logic                      va, vb, da, db;
    logic [CO*32-1:0]          fa;
    logic [CO*16-1:0]          fb;

    always #5 clk = ~clk;

    stage2_cnn_core_param #(
        .CI(CI), .CO(CO), .K(K), .IX(IX), .IY(IY), .IBW(IBW),
        .W_BW(W_BW), .B_BW(B_BW), .OBW(32), .SHIFT(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .i_cnn_weight(wvec), .i_cnn_bias(bvec),
        .i_stride2(stride2), .i_relu_en(relu), .i_in_valid(in_valid),
        .i_in_fmap(in_fmap), .o_ot_valid(va), .o_ot_fmap(fa), .o_frame_done(da)
    );

    stage2_cnn_core_param #(
        .CI(CI), .CO(CO), .K(K), .IX(IX), .IY(IY), .IBW(IBW),
        .W_BW(W_BW), .B_BW(B_BW), .OBW(16), .SHIFT(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .i_cnn_weight(wvec), .i_cnn_bias(bvec),
        .i_stride2(stride2), .i_relu_en(relu), .i_in_valid(in_valid),
        .i_in_fmap(in_fmap), .o_ot_valid(vb), .o_ot_fmap(fb), .o_frame_done(db)
    );

    typedef struct {
        int               cyc;
        logic [CO*32-1:0] fa;
        logic [CO*16-1:0] fb;
        bit               done;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, cyc = 0, npulse = 0;
    int   wt [CO][CI][K][K];
    int   bs [CO];
    int   fr [IY][IX][CI];
    int   mrow, mcol;
    bit   ms2, mrl;
    bit   prev_rst = 1'b0;
    logic signed [31:0] last_a0;
    logic signed [15:0] last_b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endfunction

    function automatic longint rq(input longint a, input int sh, input int obw, input bit rl);
        longint v, mx, mn;
        v  = a >>> sh;
        mx = (longint'(1) <<< (obw - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) v = mx;
        if (v < mn) v = mn;
        if (rl && v < 0) v = 0;
        return v;
    endfunction

    function automatic int pixval(input int pm, input int r, input int c, input int ci);
        case (pm)
            0:       return (ci == 0) ? r*IX + c : 0;
            1:       return 100;
            2:       return 524287;
            3:       return -524287;
            default: return ((r*37 + c*11 + ci*101) % 2001) - 1000;
        endcase
    endfunction

    task automatic set_weights(input int wm, input int bm);
        int t;
        for (int co = 0; co < CO; co++) begin
            for (int ci = 0; ci < CI; ci++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        case (wm)
                            0:       t = 1;
                            1:       t = -1;
                            2:       t = 127;
                            default: t = ((co*7 + ci*3 + ky*5 + kx) % 11) - 5;
                        endcase
                        wt[co][ci][ky][kx] = t;
                        wvec[((((co*CI+ci)*K+ky)*K+kx)*W_BW) +: W_BW] = t[7:0];
                    end
            t = (bm == 0) ? 0 : (bm == 1) ? 5 : co*1000 - 1500;
            bs[co] = t;
            bvec[co*B_BW +: B_BW] = t[15:0];
        end
    endtask

    task automatic push_expect();
        exp_t   e;
        longint acc;
        longint v;
        logic [63:0] vb64;
        e.fa = '0;
        e.fb = '0;
        for (int co = 0; co < CO; co++) begin
            acc = bs[co];
            for (int ci = 0; ci < CI; ci++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        acc += longint'(fr[mrow-K+1+ky][mcol-K+1+kx][ci]) * wt[co][ci][ky][kx];
            v = rq(acc, 0, 32, mrl);
            vb64 = v;
            e.fa[co*32 +: 32] = vb64[31:0];
            v = rq(acc, 2, 16, mrl);
            vb64 = v;
            e.fb[co*16 +: 16] = vb64[15:0];
        end
        e.done = ms2 ? (mrow == 10 && mcol == 10) : (mrow == IY-1 && mcol == IX-1);
        e.cyc  = cyc + 4;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_fmap  = {CI{20'h5A5A5}};
        stride2  = ~stride2;
        relu     = ~relu;
    endtask

    task automatic send_pixel(input int pm, input int idx, input bit s2, input bit rl);
        int v;
        int s;
        @(posedge clk); #1;
        if (mrow == 0 && mcol == 0) begin
            ms2 = s2;
            mrl = rl;
        end
        in_valid = 1'b1;
        stride2  = (idx % 2 == 1) ? ~s2 : s2;
        relu     = (idx % 2 == 1) ? ~rl : rl;
        for (int ci = 0; ci < CI; ci++) begin
            v = pixval(pm, mrow, mcol, ci);
            fr[mrow][mcol][ci] = v;
            in_fmap[ci*IBW +: IBW] = v[19:0];
        end
        s = ms2 ? 2 : 1;
        if (mrow >= K-1 && mcol >= K-1 && ((mrow-K+1) % s) == 0 && ((mcol-K+1) % s) == 0)
            push_expect();
        if (mcol == IX-1) begin
            mcol = 0;
            mrow = (mrow == IY-1) ? 0 : mrow + 1;
        end else begin
            mcol = mcol + 1;
        end
    endtask

    task automatic run_frame(input int pm, input bit s2, input bit rl, input int gap, input int stop_at);
        for (int idx = 0; idx < IY*IX; idx++) begin
            while ($urandom_range(0, 99) < gap) idle();
            send_pixel(pm, idx, s2, rl);
            if (idx == stop_at) return;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (prev_rst) begin
            chk("reset_flags", {va, vb, da, db}, 0);
            chk("reset_fmap_a", fa, 0);
            chk("reset_fmap_b", fb, 0);
        end
        if (va || vb) begin
            npulse++;
            last_a0 = fa[31:0];
            last_b0 = fb[15:0];
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: got fa=%h, expected no pulse", cyc, fa);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.cyc);
                chk("valid_pair", {va, vb}, 2'b11);
                chk("fmap_obw32", fa, e.fa);
                chk("fmap_obw16", fb, e.fb);
                chk("frame_done", {da, db}, {e.done, e.done});
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: got none, expected pulse at cycle %0d", e.cyc);
        end
        if (reset)
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
        prev_rst = reset;
    end

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; stride2 = 1'b0; relu = 1'b0; in_fmap = '0;
        mrow = 0; mcol = 0; ms2 = 1'b0; mrl = 1'b0;
        wvec = '0; bvec = '0;
        set_weights(0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Ramp input, stride 1, two frames back to back across the wrap.
        base = npulse;
        run_frame(0, 1'b0, 1'b0, 0, -1);
        run_frame(0, 1'b0, 1'b0, 0, -1);
        repeat (10) idle();
        chk("pulses_s1_two_frames", npulse - base, 128);
        chk("ramp_last_a", last_a0, 2925);
        chk("ramp_last_b", last_b0, 731);

        base = npulse;
        run_frame(0, 1'b1, 1'b0, 0, -1);
        repeat (10) idle();
        chk("pulses_s2", npulse - base, 16);
        chk("s2_last_a", last_a0, 2600);
        chk("s2_last_b", last_b0, 650);

        set_weights(1, 1);
        run_frame(1, 1'b0, 1'b1, 0, -1);
        repeat (10) idle();
        chk("relu_on_a", last_a0, 0);
        chk("relu_on_b", last_b0, 0);
        run_frame(1, 1'b0, 1'b0, 0, -1);
        repeat (10) idle();
        chk("neg_a", last_a0, -7495);
        chk("neg_b", last_b0, -1874);

        set_weights(2, 0);
        run_frame(2, 1'b0, 1'b0, 0, -1);
        repeat (10) idle();
        chk("sat_pos_a", last_a0, 2147483647);
        chk("sat_pos_b", last_b0, 32767);
        run_frame(3, 1'b0, 1'b0, 0, -1);
        repeat (10) idle();
        chk("sat_neg_a", last_a0, -64'sd2147483648);
        chk("sat_neg_b", last_b0, -32768);

        set_weights(3, 2);
        base = npulse;
        run_frame(4, 1'b0, 1'b0, 50, -1);
        run_frame(4, 1'b1, 1'b1, 50, -1);
        repeat (10) idle();
        chk("pulses_gapped", npulse - base, 80);

        // Reset with windows still in the pipeline; valid held high is ignored.
        run_frame(4, 1'b0, 1'b0, 0, 6*IX + 7);
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        mrow = 0; mcol = 0; ms2 = 1'b0; mrl = 1'b0;
        base = npulse;
        repeat (10) idle();
        chk("no_pulse_after_reset", npulse - base, 0);
        run_frame(4, 1'b0, 1'b0, 30, -1);
        repeat (10) idle();
        chk("pulses_after_reset", npulse - base, 64);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
